// File: rtl/hs32_mem_arbiter.sv
// hs32_mem_arbiter: shares one memory bus between the fetch port (read-only) and the exec port (read/write).
// Define HS32_ARB_RR_EN for round-robin arbitration; otherwise exec has fixed priority over fetch.
module hs32_mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] addrf,
    input  logic        stbf,
    output logic [31:0] dtrf,
    output logic        ackf,
    output logic        stlf,
    input  logic [31:0] addre,
    input  logic [31:0] dtwe,
    input  logic        rwe,
    input  logic        stbe,
    output logic [31:0] dtre,
    output logic        acke,
    output logic        stle,
    output logic [31:0] addrm,
    output logic [31:0] dtwm,
    output logic        rwm,
    output logic        stbm,
    input  logic [31:0] dtrm,
    input  logic        ackm,
    input  logic        stlm
);
    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_E, DRAIN_F} state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic            pend_f;
    logic            pend_e;
    logic [31:0]     slot_addrf;
    logic [31:0]     slot_addre;
    logic [31:0]     slot_dtwe;
    logic            slot_rwe;
    logic [TO_W-1:0] to_cnt;
    logic            cap_f;
    logic            cap_e;
    logic            req_f;
    logic            req_e;
    logic            prio_e;
    logic            grant_f;
    logic            grant_e;
    logic            timed_out;
    logic            bus_end;
    logic            ackf_nxt;
    logic            stlf_nxt;
    logic            acke_nxt;
    logic            stle_nxt;
    logic [31:0]     req_addrf;
    logic [31:0]     req_addre;
    logic [31:0]     req_dtwe;
    logic            req_rwe;

    // A request is accepted only into an empty slot whose port has nothing on the bus; flush beats a new fetch.
    assign cap_f     = stbf && !pend_f && (state != BUSY_F) && !flush;
    assign cap_e     = stbe && !pend_e && (state != BUSY_E);
    assign req_f     = (pend_f && !flush) || cap_f;
    assign req_e     = pend_e || cap_e;
    assign req_addrf = pend_f ? slot_addrf : addrf;
    assign req_addre = pend_e ? slot_addre : addre;
    assign req_dtwe  = pend_e ? slot_dtwe  : dtwe;
    assign req_rwe   = pend_e ? slot_rwe   : rwe;
    assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LIM);
    assign bus_end   = stlm || ackm || timed_out;

`ifdef HS32_ARB_RR_EN
    logic last_f;

    assign prio_e = last_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_f <= 1'b1;
        end else if (grant_f) begin
            last_f <= 1'b1;
        end else if (grant_e) begin
            last_f <= 1'b0;
        end
    end
`else
    assign prio_e = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // stlm outranks ackm; a flushed fetch completes silently.
    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_e   = 1'b0;
        ackf_nxt  = 1'b0;
        stlf_nxt  = 1'b0;
        acke_nxt  = 1'b0;
        stle_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (req_e && (!req_f || prio_e)) begin
                    grant_e   = 1'b1;
                    state_nxt = BUSY_E;
                end else if (req_f) begin
                    grant_f   = 1'b1;
                    state_nxt = BUSY_F;
                end
            end
            BUSY_F: begin
                if (bus_end) begin
                    state_nxt = IDLE;
                    ackf_nxt  = !flush && ackm && !stlm;
                    stlf_nxt  = !flush && (stlm || !ackm);
                end else if (flush) begin
                    state_nxt = DRAIN_F;
                end
            end
            BUSY_E: begin
                if (bus_end) begin
                    state_nxt = IDLE;
                    acke_nxt  = ackm && !stlm;
                    stle_nxt  = stlm || !ackm;
                end
            end
            DRAIN_F: begin
                if (bus_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_f <= 1'b0;
            pend_e <= 1'b0;
            to_cnt <= '0;
            stbm   <= 1'b0;
            ackf   <= 1'b0;
            stlf   <= 1'b0;
            acke   <= 1'b0;
            stle   <= 1'b0;
            addrm  <= '0;
            dtwm   <= '0;
            rwm    <= 1'b0;
            dtrf   <= '0;
            dtre   <= '0;
        end else begin
            pend_f <= req_f && !grant_f;
            pend_e <= req_e && !grant_e;
            stbm   <= grant_f || grant_e;
            ackf   <= ackf_nxt;
            stlf   <= stlf_nxt;
            acke   <= acke_nxt;
            stle   <= stle_nxt;
            if (grant_f || grant_e) begin
                to_cnt <= '0;
            end else if (state != IDLE) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (grant_e) begin
                addrm <= req_addre;
                dtwm  <= req_dtwe;
                rwm   <= req_rwe;
            end else if (grant_f) begin
                addrm <= req_addrf;
                dtwm  <= '0;
                rwm   <= 1'b0;
            end
            if (ackf_nxt) begin
                dtrf <= dtrm;
            end
            if (acke_nxt) begin
                dtre <= dtrm;
            end
        end
    end

    // Slot payloads need no reset: they are only read while the matching pend bit is set.
    always_ff @(posedge clk) begin
        if (cap_f) begin
            slot_addrf <= addrf;
        end
        if (cap_e) begin
            slot_addre <= addre;
            slot_dtwe  <= dtwe;
            slot_rwe   <= rwe;
        end
    end

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Testbench for hs32_mem_arbiter: vector table, hand-written corner sequences, and a randomized run
// compared each cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_hs32_mem_arbiter;
    localparam int TMO = 8;
`ifdef HS32_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        stbf;
    logic        stbe;
    logic        rwe;
    logic        ackm;
    logic        stlm;
    logic [31:0] addrf;
    logic [31:0] addre;
    logic [31:0] dtwe;
    logic [31:0] dtrm;
    logic [31:0] dtrf;
    logic [31:0] dtre;
    logic [31:0] addrm;
    logic [31:0] dtwm;
    logic        ackf;
    logic        stlf;
    logic        acke;
    logic        stle;
    logic        rwm;
    logic        stbm;

    typedef struct packed {
        logic        flush, stbf, stbe, rwe, ackm, stlm;
        logic [31:0] addrf, addre, dtwe, dtrm;
    } in_t;
    typedef struct packed {
        logic        stbm, rwm, ackf, stlf, acke, stle;
        logic [31:0] addrm, dtwm, dtrf, dtre;
    } outs_t;
    typedef struct {
        in_t   i;
        outs_t o;
    } vec_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        rw;
    } req_t;

    int checks;
    int errors;

    hs32_mem_arbiter #(.TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .addrf(addrf), .stbf(stbf), .dtrf(dtrf), .ackf(ackf), .stlf(stlf),
        .addre(addre), .dtwe(dtwe), .rwe(rwe), .stbe(stbe), .dtre(dtre), .acke(acke), .stle(stle),
        .addrm(addrm), .dtwm(dtwm), .rwm(rwm), .stbm(stbm), .dtrm(dtrm), .ackm(ackm), .stlm(stlm)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic [5:0] ci, input logic [31:0] af, input logic [31:0] ae,
                                  input logic [31:0] de, input logic [31:0] dm);
        in_t r;
        r = {ci, af, ae, de, dm};
        return r;
    endfunction

    function automatic outs_t mk_out(input logic [5:0] co, input logic [31:0] am, input logic [31:0] dw,
                                     input logic [31:0] df, input logic [31:0] dr);
        outs_t r;
        r = {co, am, dw, df, dr};
        return r;
    endfunction

    function automatic vec_t v(input logic [5:0] ci, input logic [31:0] af, input logic [31:0] ae,
                               input logic [31:0] de, input logic [31:0] dm, input logic [5:0] co,
                               input logic [31:0] am, input logic [31:0] dw, input logic [31:0] df,
                               input logic [31:0] dr);
        vec_t r;
        r.i = mk_in(ci, af, ae, de, dm);
        r.o = mk_out(co, am, dw, df, dr);
        return r;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("stbm=%b rwm=%b ackf=%b stlf=%b acke=%b stle=%b addrm=%h dtwm=%h dtrf=%h dtre=%h",
                         o.stbm, o.rwm, o.ackf, o.stlf, o.acke, o.stle, o.addrm, o.dtwm, o.dtrf, o.dtre);
    endfunction

    task automatic apply(input in_t i);
        flush = i.flush;
        stbf  = i.stbf;
        stbe  = i.stbe;
        rwe   = i.rwe;
        ackm  = i.ackm;
        stlm  = i.stlm;
        addrf = i.addrf;
        addre = i.addre;
        dtwe  = i.dtwe;
        dtrm  = i.dtrm;
    endtask

    task automatic check(input string nm, input outs_t e);
        outs_t got;
        got = {stbm, rwm, ackf, stlf, acke, stle, addrm, dtwm, dtrf, dtre};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s got: %s required: %s", nm, fmt(got), fmt(e));
        end
    endtask

    task automatic step(input string nm, input in_t i, input outs_t e);
        apply(i);
        @(posedge clk);
        @(negedge clk);
        check(nm, e);
    endtask

    task automatic do_reset();
        apply('0);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: one pending queue per port, a bus owner and a grant timestamp.
    outs_t m_o;
    bit    m_busy, m_fown, m_drain, m_lastf;
    int    m_start, m_cyc;
    req_t  fq[$];
    req_t  eq[$];

    task automatic model_init();
        m_o     = '0;
        m_busy  = 1'b0;
        m_fown  = 1'b0;
        m_drain = 1'b0;
        m_lastf = 1'b1;
        m_start = 0;
        m_cyc   = 0;
        fq.delete();
        eq.delete();
    endtask

    task automatic model_step(input in_t i);
        bit   f_fly, e_fly, was_idle, pick_e, done;
        req_t r;
        f_fly    = m_busy && m_fown && !m_drain;
        e_fly    = m_busy && !m_fown;
        was_idle = !m_busy;
        m_o.stbm = 1'b0;
        m_o.ackf = 1'b0;
        m_o.stlf = 1'b0;
        m_o.acke = 1'b0;
        m_o.stle = 1'b0;
        if (m_busy) begin
            done = i.stlm || i.ackm || (TMO != 0 && (m_cyc - m_start) == TMO);
            if (done) begin
                m_busy = 1'b0;
                if (!m_fown) begin
                    if (i.ackm && !i.stlm) begin
                        m_o.acke = 1'b1;
                        m_o.dtre = i.dtrm;
                    end else begin
                        m_o.stle = 1'b1;
                    end
                end else if (!m_drain && !i.flush) begin
                    if (i.ackm && !i.stlm) begin
                        m_o.ackf = 1'b1;
                        m_o.dtrf = i.dtrm;
                    end else begin
                        m_o.stlf = 1'b1;
                    end
                end
            end else if (f_fly && i.flush) begin
                m_drain = 1'b1;
            end
        end
        if (i.flush) fq.delete();
        if (i.stbf && !i.flush && fq.size() == 0 && !f_fly) begin
            r.a = i.addrf; r.d = '0; r.rw = 1'b0;
            fq.push_back(r);
        end
        if (i.stbe && eq.size() == 0 && !e_fly) begin
            r.a = i.addre; r.d = i.dtwe; r.rw = i.rwe;
            eq.push_back(r);
        end
        if (was_idle && (fq.size() != 0 || eq.size() != 0)) begin
            pick_e = (eq.size() != 0) && (fq.size() == 0 || !RR || m_lastf);
            if (pick_e) r = eq.pop_front();
            else        r = fq.pop_front();
            m_o.stbm  = 1'b1;
            m_o.addrm = r.a;
            m_o.dtwm  = r.d;
            m_o.rwm   = r.rw;
            m_busy    = 1'b1;
            m_fown    = !pick_e;
            m_drain   = 1'b0;
            m_lastf   = !pick_e;
            m_start   = m_cyc + 1;
        end
        m_cyc++;
    endtask

    initial begin
        vec_t  tbl[$];
        outs_t e;
        int    ack_pct;
        checks = 0;
        errors = 0;

        // ci = {flush,stbf,stbe,rwe,ackm,stlm}; co = {stbm,rwm,ackf,stlf,acke,stle}
        tbl.push_back(v(6'b010000, 32'h100, 32'h0,   32'h0,  32'h0,        6'b100000, 32'h100, 32'h0,  32'h0,        32'h0));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b000000, 32'h100, 32'h0,  32'h0,        32'h0));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b000000, 32'h100, 32'h0,  32'h0,        32'h0));
        tbl.push_back(v(6'b000010, 32'h0,   32'h0,   32'h0,  32'hDEADBEEF, 6'b001000, 32'h100, 32'h0,  32'hDEADBEEF, 32'h0));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b000000, 32'h100, 32'h0,  32'hDEADBEEF, 32'h0));
        tbl.push_back(v(6'b011100, 32'h100, 32'h200, 32'h55, 32'h0,        6'b110000, 32'h200, 32'h55, 32'hDEADBEEF, 32'h0));
        tbl.push_back(v(6'b000010, 32'h0,   32'h0,   32'h0,  32'h11111111, 6'b010010, 32'h200, 32'h55, 32'hDEADBEEF, 32'h11111111));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b100000, 32'h100, 32'h0,  32'hDEADBEEF, 32'h11111111));
        tbl.push_back(v(6'b000010, 32'h0,   32'h0,   32'h0,  32'h22222222, 6'b001000, 32'h100, 32'h0,  32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b000000, 32'h100, 32'h0,  32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b001000, 32'h0,   32'h300, 32'h0,  32'h0,        6'b100000, 32'h300, 32'h0,  32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b000011, 32'h0,   32'h0,   32'h0,  32'h33333333, 6'b000001, 32'h300, 32'h0,  32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b000000, 32'h300, 32'h0,  32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b010000, 32'h500, 32'h0,   32'h0,  32'h0,        6'b100000, 32'h500, 32'h0,  32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b000001, 32'h0,   32'h0,   32'h0,  32'h0,        6'b000100, 32'h500, 32'h0,  32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b000000, 32'h500, 32'h0,  32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b001100, 32'h0,   32'h600, 32'hAA, 32'h0,        6'b110000, 32'h600, 32'hAA, 32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b001100, 32'h0,   32'h700, 32'hBB, 32'h0,        6'b010000, 32'h600, 32'hAA, 32'h22222222, 32'h11111111));
        tbl.push_back(v(6'b000010, 32'h0,   32'h0,   32'h0,  32'h44444444, 6'b010010, 32'h600, 32'hAA, 32'h22222222, 32'h44444444));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b010000, 32'h600, 32'hAA, 32'h22222222, 32'h44444444));
        tbl.push_back(v(6'b000000, 32'h0,   32'h0,   32'h0,  32'h0,        6'b010000, 32'h600, 32'hAA, 32'h22222222, 32'h44444444));

        do_reset();
        check("reset_state", '0);
        foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

        // Flush while a fetch is in flight, then a new fetch latched during the drain.
        do_reset();
        step("flush_grant", mk_in(6'b010000, 32'h300, 0, 0, 0), mk_out(6'b100000, 32'h300, 0, 0, 0));
        step("flush_hit", mk_in(6'b100000, 0, 0, 0, 0), mk_out(6'b000000, 32'h300, 0, 0, 0));
        step("flush_newreq", mk_in(6'b010000, 32'h400, 0, 0, 0), mk_out(6'b000000, 32'h300, 0, 0, 0));
        step("flush_oldack", mk_in(6'b000010, 0, 0, 0, 32'hBAD0BAD0), mk_out(6'b000000, 32'h300, 0, 0, 0));
        step("flush_regrant", mk_in(6'b000000, 0, 0, 0, 0), mk_out(6'b100000, 32'h400, 0, 0, 0));
        step("flush_newack", mk_in(6'b000010, 0, 0, 0, 32'h12345678), mk_out(6'b001000, 32'h400, 0, 32'h12345678, 0));
        step("flush_quiet", mk_in(6'b000000, 0, 0, 0, 0), mk_out(6'b000000, 32'h400, 0, 32'h12345678, 0));

        // Watchdog: silent memory, stle nine cycles after stbm, late ack ignored.
        do_reset();
        step("tmo_grant", mk_in(6'b001000, 0, 32'h800, 0, 0), mk_out(6'b100000, 32'h800, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            step($sformatf("tmo_wait%0d", k), mk_in(6'b000000, 0, 0, 0, 0), mk_out(6'b000000, 32'h800, 0, 0, 0));
        step("tmo_fire", mk_in(6'b000000, 0, 0, 0, 0), mk_out(6'b000001, 32'h800, 0, 0, 0));
        step("tmo_lateack", mk_in(6'b000010, 0, 0, 0, 32'hFFFF0000), mk_out(6'b000000, 32'h800, 0, 0, 0));
        step("tmo_next", mk_in(6'b010000, 32'h900, 0, 0, 0), mk_out(6'b100000, 32'h900, 0, 0, 0));

        // Asynchronous reset during an exec transaction.
        do_reset();
        step("rst_grant", mk_in(6'b001100, 0, 32'hA00, 32'h5A, 0), mk_out(6'b110000, 32'hA00, 32'h5A, 0, 0));
        step("rst_busy", mk_in(6'b000000, 0, 0, 0, 0), mk_out(6'b010000, 32'hA00, 32'h5A, 0, 0));
        reset = 1'b1;
        #1;
        check("rst_async", '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step("rst_staleack", mk_in(6'b000010, 0, 0, 0, 32'h0BADF00D), '0);
        step("rst_newreq", mk_in(6'b010000, 32'hB00, 0, 0, 0), mk_out(6'b100000, 32'hB00, 0, 0, 0));
        step("rst_newack", mk_in(6'b000010, 0, 0, 0, 32'hCAFEF00D), mk_out(6'b001000, 32'hB00, 0, 32'hCAFEF00D, 0));

        // Randomized traffic against the reference model.
        do_reset();
        model_init();
        ack_pct = 30;
        for (int n = 0; n < 3000 && errors < 40; n++) begin
            in_t r;
            if (n % 200 == 0) ack_pct = $urandom_range(5, 50);
            r.flush = ($urandom_range(0, 19) == 0);
            r.stbf  = ($urandom_range(0, 2) == 0);
            r.stbe  = ($urandom_range(0, 2) == 0);
            r.rwe   = $urandom_range(0, 1);
            r.ackm  = ($urandom_range(0, 99) < ack_pct);
            r.stlm  = ($urandom_range(0, 11) == 0);
            r.addrf = $urandom;
            r.addre = $urandom;
            r.dtwe  = $urandom;
            r.dtrm  = $urandom;
            apply(r);
            @(posedge clk);
            model_step(r);
            @(negedge clk);
            check($sformatf("rand%0d", n), m_o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
